word_collector: RTL and testbench

- Transmit-side counterpart to the array-port register stage.
- Takes a serial stream of N-bit words on a valid/ready handshake and assembles M consecutive words into one frame.
- Presents the frame on an unpacked-array output port q [M] of packed N-bit vectors, with its own valid/ready handshake.
- Internal fill buffer plus output buffer, so the next frame can fill while the current one waits for downstream.

---
 rtl/word_collector_pkg.sv | 21 ++
 rtl/word_collector.sv | 128 ++++++++++++
 tb/tb_word_collector.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_collector_pkg.sv
// Shared types and helpers for the word collector: FSM state encoding and
// the lane-validity mask used to zero-pad short frames.
package word_collector_pkg;

   typedef enum logic {
      FILL,
      HOLD
   } state_e;

   localparam int unsigned MAX_LANES = 64;

   // Bit i is set when lane i carries a real word of a frame of length len.
   function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned len);
      logic [MAX_LANES-1:0] mask;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         mask[i] = (i < len);
      end
      return mask;
   endfunction

endpackage

// File: rtl/word_collector.sv
// Assembles M serial N-bit words into one frame on an unpacked-array port,
// with a fill bank that keeps accepting words while the output bank waits.
module word_collector
   import word_collector_pkg::*;
#(
   parameter int N  = 2,
   parameter int M  = 2,
   parameter int LW = $clog2(M + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [N-1:0]  in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [N-1:0]  q [M],
   output logic [LW-1:0] out_len,
   output logic          out_valid,
   input  logic          out_ready
);

   state_e        state_q, state_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] hold_len_q, hold_len_d;
   logic [LW-1:0] out_len_q, out_len_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  fill_q [M];
   logic [N-1:0]  fill_d [M];
   logic [N-1:0]  q_q [M];
   logic [N-1:0]  q_d [M];

   logic          acc;
   logic          complete;
   logic          free;
   logic          xfer;
   logic          bypass;
   logic [LW-1:0] xfer_len;
   logic [M-1:0]  mask;

   assign in_ready = (state_q == FILL) && reset_n;
   assign acc      = in_valid && in_ready;
   assign complete = acc && ((cnt_q == LW'(M - 1)) || in_last);
   assign free     = !out_valid_q || out_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_len_d = hold_len_q;
      xfer       = 1'b0;
      bypass     = 1'b0;
      xfer_len   = (state_q == HOLD) ? hold_len_q : (cnt_q + LW'(1));
      case (state_q)
         FILL: begin
            if (acc) begin
               if (!complete) begin
                  cnt_d = cnt_q + LW'(1);
               end else if (free) begin
                  xfer   = 1'b1;
                  bypass = 1'b1;
                  cnt_d  = '0;
               end else begin
                  hold_len_d = cnt_q + LW'(1);
                  state_d    = HOLD;
               end
            end
         end
         HOLD: begin
            if (free) begin
               xfer    = 1'b1;
               cnt_d   = '0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // The completing word is taken straight from in_data so a frame reaches q
   // on the same edge its last word is accepted.
   always_comb begin
      mask   = M'(lane_mask(int'(xfer_len)));
      fill_d = fill_q;
      q_d    = q_q;
      for (int i = 0; i < M; i++) begin
         if (acc && (cnt_q == LW'(i))) begin
            fill_d[i] = in_data;
         end
         if (xfer) begin
            if (!mask[i]) begin
               q_d[i] = '0;
            end else if (bypass && (cnt_q == LW'(i))) begin
               q_d[i] = in_data;
            end else begin
               q_d[i] = fill_q[i];
            end
         end
      end
      out_len_d   = xfer ? xfer_len : out_len_q;
      out_valid_d = xfer ? 1'b1 : (out_valid_q && !out_ready);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         hold_len_q  <= '0;
         out_len_q   <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < M; i++) begin
            fill_q[i] <= '0;
            q_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_len_q  <= hold_len_d;
         out_len_q   <= out_len_d;
         out_valid_q <= out_valid_d;
         fill_q      <= fill_d;
         q_q         <= q_d;
      end
   end

   assign q         = q_q;
   assign out_len   = out_len_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_word_collector.sv
// Bench for word_collector: a frame-queue model checks the N=8/M=4 instance
// every cycle; small N=2/M=2 and N=4/M=1 instances get hand-computed vectors.
module tb_word_collector;

   logic clock;
   logic reset_n;

   int total = 0;
   int bad   = 0;

   logic [7:0] a_in_data;
   logic       a_in_valid, a_in_last, a_in_ready;
   logic [7:0] a_q [4];
   logic [2:0] a_out_len;
   logic       a_out_valid, a_out_ready;

   logic [1:0] b_in_data;
   logic       b_in_valid, b_in_last, b_in_ready;
   logic [1:0] b_q [2];
   logic [1:0] b_out_len;
   logic       b_out_valid, b_out_ready;

   logic [3:0] c_in_data;
   logic       c_in_valid, c_in_last, c_in_ready;
   logic [3:0] c_q [1];
   logic [0:0] c_out_len;
   logic       c_out_valid, c_out_ready;

   word_collector #(.N(8), .M(4)) dut_a (
      .clock(clock), .reset_n(reset_n),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
      .q(a_q), .out_len(a_out_len), .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   word_collector #(.N(2), .M(2)) dut_b (
      .clock(clock), .reset_n(reset_n),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
      .q(b_q), .out_len(b_out_len), .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   word_collector #(.N(4), .M(1)) dut_c (
      .clock(clock), .reset_n(reset_n),
      .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(c_in_ready),
      .q(c_q), .out_len(c_out_len), .out_valid(c_out_valid), .out_ready(c_out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Model for instance A: frames completed but not yet consumed, in order.
   // One is on q, a second may be waiting; input stalls only when two are pending.
   typedef struct {
      logic [31:0] data;
      int          len;
   } frame_t;

   frame_t      frames[$];
   logic [31:0] part_data = '0;
   int          part_len  = 0;
   int          m_words   = 0;

   always @(posedge clock or negedge reset_n) begin
      bit     m_acc, m_con;
      frame_t f;
      if (!reset_n) begin
         frames.delete();
         part_data = '0;
         part_len  = 0;
      end else begin
         m_acc = a_in_valid && (frames.size() < 2);
         m_con = (frames.size() > 0) && a_out_ready;
         if (m_con) f = frames.pop_front();
         if (m_acc) begin
            part_data[8*part_len +: 8] = a_in_data;
            part_len++;
            m_words++;
            if (part_len == 4 || a_in_last) begin
               f.data = part_data;
               f.len  = part_len;
               frames.push_back(f);
               part_data = '0;
               part_len  = 0;
            end
         end
      end
   end

   always @(negedge clock) begin
      checkOutput("a_in_ready", a_in_ready, reset_n && (frames.size() < 2));
      checkOutput("a_out_valid", a_out_valid, frames.size() > 0);
      if (frames.size() > 0) begin
         checkOutput("a_out_len", a_out_len, frames[0].len);
         for (int i = 0; i < 4; i++) begin
            checkOutput("a_q_lane", a_q[i], frames[0].data[8*i +: 8]);
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] d, input logic last);
      bit done = 0;
      a_in_valid = 1'b1;
      a_in_data  = d;
      a_in_last  = last;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clock);
         done = a_in_ready;
         @(posedge clock);
         #1;
      end
      if (!done) checkOutput("a_accept_timeout", 0, 1);
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
   endtask

   task automatic checkA(input string name, input logic [31:0] lanes, input int len);
      checkOutput({name, "_valid"}, a_out_valid, 1);
      checkOutput({name, "_len"}, a_out_len, len);
      for (int i = 0; i < 4; i++) checkOutput({name, "_q"}, a_q[i], lanes[8*i +: 8]);
   endtask

   initial begin
      int cycles;
      int start;
      reset_n = 1'b0;
      a_in_data = '0; a_in_valid = 0; a_in_last = 0; a_out_ready = 0;
      b_in_data = '0; b_in_valid = 0; b_in_last = 0; b_out_ready = 0;
      c_in_data = '0; c_in_valid = 0; c_in_last = 0; c_out_ready = 0;

      @(negedge clock);
      checkOutput("rst_a_in_ready", a_in_ready, 0);
      checkOutput("rst_a_out_valid", a_out_valid, 0);
      checkOutput("rst_a_out_len", a_out_len, 0);
      checkOutput("rst_a_q3", a_q[3], 0);
      checkOutput("rst_b_in_ready", b_in_ready, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // Two-word frames streamed back-to-back
      @(negedge clock);
      b_out_ready = 1; b_in_valid = 1; b_in_data = 2'd1;
      @(negedge clock);
      checkOutput("b_s1_ready", b_in_ready, 1);
      checkOutput("b_s1_valid", b_out_valid, 0);
      b_in_data = 2'd2;
      @(negedge clock);
      checkOutput("b_s2_valid", b_out_valid, 1);
      checkOutput("b_s2_q0", b_q[0], 1);
      checkOutput("b_s2_q1", b_q[1], 2);
      checkOutput("b_s2_len", b_out_len, 2);
      checkOutput("b_s2_ready", b_in_ready, 1);
      b_in_data = 2'd3;
      @(negedge clock);
      checkOutput("b_s3_valid", b_out_valid, 0);
      checkOutput("b_s3_ready", b_in_ready, 1);
      b_in_data = 2'd0;
      @(negedge clock);
      checkOutput("b_s4_valid", b_out_valid, 1);
      checkOutput("b_s4_q0", b_q[0], 3);
      checkOutput("b_s4_q1", b_q[1], 0);
      checkOutput("b_s4_len", b_out_len, 2);
      b_in_valid = 0;
      @(negedge clock);
      checkOutput("b_s5_valid", b_out_valid, 0);

      // Backpressure: second frame waits in HOLD until downstream frees
      b_out_ready = 0; b_in_valid = 1; b_in_data = 2'd1;
      @(negedge clock);
      b_in_data = 2'd2;
      @(negedge clock);
      checkOutput("b_h1_valid", b_out_valid, 1);
      checkOutput("b_h1_q0", b_q[0], 1);
      checkOutput("b_h1_q1", b_q[1], 2);
      b_in_data = 2'd3;
      @(negedge clock);
      checkOutput("b_h2_ready", b_in_ready, 1);
      b_in_data = 2'd1;
      @(negedge clock);
      checkOutput("b_h3_ready", b_in_ready, 0);
      checkOutput("b_h3_q0", b_q[0], 1);
      b_in_valid = 0;
      @(negedge clock);
      checkOutput("b_h4_ready", b_in_ready, 0);
      checkOutput("b_h4_q1", b_q[1], 2);
      b_out_ready = 1;
      @(negedge clock);
      checkOutput("b_h5_valid", b_out_valid, 1);
      checkOutput("b_h5_q0", b_q[0], 3);
      checkOutput("b_h5_q1", b_q[1], 1);
      checkOutput("b_h5_len", b_out_len, 2);
      checkOutput("b_h5_ready", b_in_ready, 1);
      b_out_ready = 0;
      @(negedge clock);
      checkOutput("b_h6_valid", b_out_valid, 1);
      checkOutput("b_h6_q0", b_q[0], 3);
      b_out_ready = 1;
      @(negedge clock);
      checkOutput("b_h7_valid", b_out_valid, 0);

      // Single-lane frames, one per cycle
      c_out_ready = 1; c_in_valid = 1; c_in_data = 4'hF;
      @(negedge clock);
      checkOutput("c_1_valid", c_out_valid, 1);
      checkOutput("c_1_q0", c_q[0], 4'hF);
      checkOutput("c_1_len", c_out_len, 1);
      checkOutput("c_1_ready", c_in_ready, 1);
      c_in_data = 4'h3;
      @(negedge clock);
      checkOutput("c_2_valid", c_out_valid, 1);
      checkOutput("c_2_q0", c_q[0], 4'h3);
      c_in_data = 4'h9;
      @(negedge clock);
      checkOutput("c_3_q0", c_q[0], 4'h9);
      c_in_valid = 0;
      @(negedge clock);
      checkOutput("c_4_valid", c_out_valid, 0);

      // Short frames on the four-lane instance
      @(posedge clock); #1;
      a_out_ready = 1;
      applyStimulus(8'hA5, 1'b1);
      @(negedge clock);
      checkA("a_short1", 32'h0000_00A5, 1);
      @(posedge clock); #1;
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b1);
      @(negedge clock);
      checkA("a_short3", 32'h0033_2211, 3);

      // Async reset mid-frame discards the partial frame
      @(posedge clock); #1;
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_out_len", a_out_len, 0);
      checkOutput("arst_out_valid", a_out_valid, 0);
      checkOutput("arst_in_ready", a_in_ready, 0);
      checkOutput("arst_q0", a_q[0], 0);
      checkOutput("arst_q2", a_q[2], 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      applyStimulus(8'h44, 1'b0);
      applyStimulus(8'h55, 1'b0);
      applyStimulus(8'h66, 1'b0);
      applyStimulus(8'h77, 1'b0);
      @(negedge clock);
      checkA("a_post_rst", 32'h7766_5544, 4);

      // Random gaps on both handshakes
      @(posedge clock); #1;
      cycles = 0;
      start  = m_words;
      while ((m_words - start) < 1000 && cycles < 20000) begin
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_data   = 8'($urandom_range(0, 255));
         a_in_last   = ($urandom_range(0, 4) == 0);
         a_out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clock); #1;
         cycles++;
      end
      checkOutput("a_random_words", m_words - start, 1000);
      a_in_valid  = 0;
      a_in_last   = 0;
      a_out_ready = 1;
      repeat (6) @(posedge clock);
      @(negedge clock);
      checkOutput("a_drain_valid", a_out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
